// File: rtl/capture_arbiter_if.sv
// Handshake bundle between requesters/consumer and the capture arbiter.
// The master side drives requests and the consumer acknowledge.
interface capture_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]         req_valid;
  logic [N-1:0][W-1:0]  req_data;
  logic [N-1:0]         req_ready;
  logic                 cap_en;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic [SW-1:0]        out_src;
  logic                 out_ready;
  logic                 timeout_err;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, cap_en, out_valid, out_data, out_src, timeout_err
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, cap_en, out_valid, out_data, out_src, timeout_err
  );
endinterface

// File: rtl/capture_arbiter.sv
// Round-robin arbiter feeding a single capture register; holds one result
// until acknowledged or until TIMEOUT cycles pass, then drops it.
module capture_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  capture_arbiter_if.slave  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] src_q, src_d;
  logic [W-1:0]  data_q, data_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [SW-1:0] cand;
  logic [SW-1:0] win;
  logic          found;
  logic [N-1:0]  grant;
  logic          last_cnt;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = SW'((int'(ptr_q) + k) % N);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant is gated by reset so nothing is offered while reset is held.
  assign grant    = (state_q == IDLE && found && reset) ? (N'(1) << win) : '0;
  assign last_cnt = (cnt_q == 8'(TIMEOUT - 1));

  assign bus.req_ready   = grant;
  assign bus.cap_en      = |grant;
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_data    = data_q;
  assign bus.out_src     = src_q;
  assign bus.timeout_err = (state_q == HOLD) && !bus.out_ready && last_cnt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = HOLD;
          ptr_d   = win;
          src_d   = win;
          data_d  = bus.req_data[win];
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (bus.out_ready || last_cnt) state_d = IDLE;
        else                           cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= SW'(N - 1);
      src_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_capture_arbiter.sv
// Directed bench for capture_arbiter: reset priority, round-robin order,
// data capture, timeout drop, ack on the timeout cycle and async reset.
module tb_capture_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  capture_arbiter_if #(.N(N), .W(W)) bus ();

  capture_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // reset state, with requests present
    @(negedge clk);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) bus.req_data[i] = 8'(8'h10 + i);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data",  32'(bus.out_data),  32'(0));
    chk("rst_out_src",   32'(bus.out_src),   32'(0));
    chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_cap_en",    32'(bus.cap_en),    32'(0));
    chk("rst_timeout",   32'(bus.timeout_err), 32'(0));

    // reset priority then round-robin 0,1,2,3,0 with out_ready held high
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_grant",  32'(bus.req_ready), 32'(1) << (g % N));
      chk("rr_cap_en", 32'(bus.cap_en),    32'(1));
      @(negedge clk);
      #1;
      chk("rr_out_valid", 32'(bus.out_valid), 32'(1));
      chk("rr_out_src",   32'(bus.out_src),   32'(g % N));
      chk("rr_out_data",  32'(bus.out_data),  32'(8'h10 + (g % N)));
      chk("rr_hold_noreq", 32'(bus.req_ready), 32'(0));
      @(negedge clk);
    end

    // data capture: ptr=0, only requester 2 asks
    bus.req_valid   = 4'b0100;
    bus.req_data[2] = 8'hA5;
    bus.out_ready   = 1'b0;
    #1;
    chk("cap_grant", 32'(bus.req_ready), 32'(4'b0100));
    for (int h = 1; h <= 4; h++) begin
      @(negedge clk);
      bus.req_valid   = '0;
      bus.req_data[2] = 8'h3C;
      bus.out_ready   = (h == 4);
      #1;
      chk("cap_valid",   32'(bus.out_valid),   32'(1));
      chk("cap_data",    32'(bus.out_data),    32'(8'hA5));
      chk("cap_src",     32'(bus.out_src),     32'(2));
      chk("cap_timeout", 32'(bus.timeout_err), 32'(0));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("cap_done", 32'(bus.out_valid), 32'(0));

    // timeout: ptr=2, requester 1 asks, never acknowledged
    bus.req_valid = 4'b0010;
    #1;
    chk("to_grant", 32'(bus.req_ready), 32'(4'b0010));
    for (int h = 1; h <= TO; h++) begin
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("to_valid", 32'(bus.out_valid),   32'(1));
      chk("to_err",   32'(bus.timeout_err), 32'(h == TO));
    end
    @(negedge clk);
    #1;
    chk("to_idle",     32'(bus.out_valid),   32'(0));
    chk("to_err_gone", 32'(bus.timeout_err), 32'(0));

    // ptr kept at 1 after drop: 0 and 1 ask, search 2,3,0 -> 0
    bus.req_valid = 4'b0011;
    #1;
    chk("ptr_kept_grant", 32'(bus.req_ready), 32'(4'b0001));
    for (int h = 1; h <= TO; h++) begin
      @(negedge clk);
      bus.req_valid = '0;
      bus.out_ready = (h == TO);
      #1;
      chk("ack16_valid", 32'(bus.out_valid),   32'(1));
      chk("ack16_err",   32'(bus.timeout_err), 32'(0));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("ack16_idle", 32'(bus.out_valid), 32'(0));

    // async reset mid-HOLD: ptr=0, requester 2 captured, then reset between edges
    bus.req_valid = 4'b0100;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("ar_hold", 32'(bus.out_valid), 32'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid),   32'(0));
    chk("ar_data",  32'(bus.out_data),    32'(0));
    chk("ar_src",   32'(bus.out_src),     32'(0));
    chk("ar_err",   32'(bus.timeout_err), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    chk("ar_grant3", 32'(bus.req_ready), 32'(4'b1000));
    @(negedge clk);
    #1;
    chk("ar_src3",   32'(bus.out_src),   32'(3));
    chk("ar_valid3", 32'(bus.out_valid), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
